// File: rtl/spi_arbiter_if.sv
// Bundle of request/response and SPI-master-side signals for spi_arbiter.
// slave  : the arbiter's view (takes requests, drives the SPI master controls).
// master : the environment's view (requesters plus the SPI master).
interface spi_arbiter_if;
    logic [3:0]   req_valid;
    logic [127:0] req_mosi;
    logic [23:0]  req_nbits;
    logic [3:0]   req_ack;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_miso;
    logic         busy;
    logic [1:0]   grant_id;
    logic [31:0]  m_mosi_data;
    logic [5:0]   m_nbits;
    logic         m_request;
    logic         m_ready;
    logic [31:0]  m_miso_data;
    logic         m_spi_csn;
    logic [3:0]   spi_csn_out;

    modport slave (
        input  req_valid, req_mosi, req_nbits, m_ready, m_miso_data, m_spi_csn,
        output req_ack, rsp_valid, rsp_miso, busy, grant_id,
               m_mosi_data, m_nbits, m_request, spi_csn_out
    );

    modport master (
        output req_valid, req_mosi, req_nbits, m_ready, m_miso_data, m_spi_csn,
        input  req_ack, rsp_valid, rsp_miso, busy, grant_id,
               m_mosi_data, m_nbits, m_request, spi_csn_out
    );
endinterface

// File: rtl/spi_arbiter.sv
// Four-way round-robin arbiter sharing one SPI master between requesters.
//
// state    | meaning
// IDLE     | no transfer; arbitrate pending req_valid
// ISSUE    | m_request pulse cycle, master accepts the job
// WAIT     | transfer running, waiting for m_ready
// GAP_WAIT | post-transfer idle gap, still busy
module spi_arbiter #(
    parameter int unsigned GAP           = 0,
    parameter int unsigned DEFAULT_NBITS = 7
) (
    input  logic   clk_in,
    input  logic   nrst,
    spi_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP_WAIT} state_t;

    localparam logic [5:0]  NBITS_IDLE = 6'(DEFAULT_NBITS);
    localparam logic [15:0] GAP_LOAD   = (GAP == 0) ? 16'd0 : 16'(GAP - 1);

    state_t      r_state;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_grant_id;
    logic [15:0] r_gap_cnt;
    logic        r_busy;
    logic        r_m_request;
    logic [3:0]  r_req_ack;
    logic [3:0]  r_rsp_valid;
    logic [31:0] r_rsp_miso;
    logic [31:0] r_m_mosi_data;
    logic [5:0]  r_m_nbits;

    logic        w_found;
    logic [1:0]  w_idx;
    logic [1:0]  w_winner;
    logic [3:0]  w_csn;

    // Round-robin pick: first pending requester after the last one served.
    always_comb begin
        w_found  = 1'b0;
        w_idx    = r_last_grant;
        w_winner = r_last_grant;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last_grant + 2'(k);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // Sequencer: grant, issue, wait for completion, optional gap.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            r_state       <= IDLE;
            r_last_grant  <= 2'd3;
            r_grant_id    <= 2'd0;
            r_gap_cnt     <= 16'd0;
            r_busy        <= 1'b0;
            r_m_request   <= 1'b0;
            r_req_ack     <= 4'b0000;
            r_rsp_valid   <= 4'b0000;
            r_rsp_miso    <= 32'd0;
            r_m_mosi_data <= 32'd0;
            r_m_nbits     <= NBITS_IDLE;
        end else begin
            r_req_ack   <= 4'b0000;
            r_rsp_valid <= 4'b0000;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id    <= w_winner;
                        r_m_mosi_data <= bus.req_mosi[32*w_winner +: 32];
                        r_m_nbits     <= bus.req_nbits[6*w_winner +: 6];
                        r_m_request   <= 1'b1;
                        r_req_ack     <= 4'b0001 << w_winner;
                        r_busy        <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_m_request <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (bus.m_ready) begin
                        r_rsp_miso   <= bus.m_miso_data;
                        r_rsp_valid  <= 4'b0001 << r_grant_id;
                        r_last_grant <= r_grant_id;
                        if (GAP == 0) begin
                            r_busy        <= 1'b0;
                            r_m_mosi_data <= 32'd0;
                            r_m_nbits     <= NBITS_IDLE;
                            r_state       <= IDLE;
                        end else begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= GAP_WAIT;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (r_gap_cnt == 16'd0) begin
                        r_busy        <= 1'b0;
                        r_m_mosi_data <= 32'd0;
                        r_m_nbits     <= NBITS_IDLE;
                        r_state       <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Route the master's chip select only to the device currently granted.
    always_comb begin
        w_csn = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (r_busy && (r_grant_id == 2'(i))) w_csn[i] = bus.m_spi_csn;
        end
    end

    assign bus.req_ack     = r_req_ack;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_miso    = r_rsp_miso;
    assign bus.busy        = r_busy;
    assign bus.grant_id    = r_grant_id;
    assign bus.m_mosi_data = r_m_mosi_data;
    assign bus.m_nbits     = r_m_nbits;
    assign bus.m_request   = r_m_request;
    assign bus.spi_csn_out = w_csn;
endmodule
